// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one VRAM port between the renderer (fixed-latency fetches that
// always win) and a CPU access channel with an auto-incrementing address
// register and a buffered read path.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_rend                   renderer active; fetch strobes honoured only when 1
//   i_fetch_nt/attr/chr      renderer fetch strobes (at most one per cycle)
//   i_rend_addr[13:0]        address of the current renderer fetch
//   o_rend_data[7:0]         renderer read data (registered copy of i_vram_rdata)
//   i_vaddr_load, i_vaddr_in load the CPU VRAM address register
//   i_inc32                  CPU address step: 0 = +1, 1 = +32
//   i_cpu_req                one-cycle request pulse; i_cpu_we/i_cpu_wdata sampled with it
//   o_cpu_ack                one-cycle completion pulse
//   o_cpu_rdata[7:0]         read buffer returned to the CPU
//   o_busy                   CPU request pending, in flight, or being acknowledged
//   o_vram_addr/rd/wr/wdata  VRAM port (combinational, rd and wr mutually exclusive)
//   i_vram_rdata[7:0]        VRAM read data, valid the cycle after o_vram_rd
//   o_state[1:0], o_vaddr    debug view of the FSM state and the CPU address register
//
// Handshake: i_cpu_req is accepted only while o_busy=0. After acceptance the
// channel stays busy until the cycle in which o_cpu_ack=1; exactly one ack
// is produced per accepted request unless rst abandons it.
module vram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rend,
  input  logic        i_fetch_nt,
  input  logic        i_fetch_attr,
  input  logic        i_fetch_chr,
  input  logic [13:0] i_rend_addr,
  output logic [7:0]  o_rend_data,
  input  logic        i_vaddr_load,
  input  logic [13:0] i_vaddr_in,
  input  logic        i_inc32,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_busy,
  output logic [13:0] o_vram_addr,
  output logic        o_vram_rd,
  output logic        o_vram_wr,
  output logic [7:0]  o_vram_wdata,
  input  logic [7:0]  i_vram_rdata,
  output logic [1:0]  o_state,
  output logic [13:0] o_vaddr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [13:0] r_vaddr;
  logic        r_we;
  logic [7:0]  r_wdata;
  logic        r_ack;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  r_rend_data;
  logic        r_rend_p1;

  logic        w_rend_grant;
  logic        w_cpu_grant;
  logic        w_accept;
  logic        w_complete;
  logic [13:0] w_step;
  logic [13:0] w_vram_addr;
  logic        w_vram_rd;
  logic        w_vram_wr;
  logic [7:0]  w_vram_wdata;

  assign w_rend_grant = i_rend & (i_fetch_nt | i_fetch_attr | i_fetch_chr);
  assign w_cpu_grant  = (r_state == ST_PEND) & ~w_rend_grant;
  // A request in the ack cycle is still "busy" and must be dropped.
  assign w_accept     = (r_state == ST_IDLE) & i_cpu_req & ~r_ack;
  // Completion: a granted write, or the capture cycle of a read.
  assign w_complete   = (w_cpu_grant & r_we) | (r_state == ST_RDWAIT);
  assign w_step       = i_inc32 ? 14'd32 : 14'd1;

  always_comb begin
    w_next       = r_state;
    w_vram_addr  = 14'd0;
    w_vram_rd    = 1'b0;
    w_vram_wr    = 1'b0;
    w_vram_wdata = 8'd0;
    if (w_rend_grant) begin
      w_vram_addr = i_rend_addr;
      w_vram_rd   = 1'b1;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_PEND;
      end
      ST_PEND: begin
        if (w_cpu_grant) begin
          w_vram_addr = r_vaddr;
          if (r_we) begin
            w_vram_wr    = 1'b1;
            w_vram_wdata = r_wdata;
            w_next       = ST_IDLE;
          end else begin
            w_vram_rd = 1'b1;
            w_next    = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vaddr     <= 14'd0;
      r_we        <= 1'b0;
      r_wdata     <= 8'd0;
      r_ack       <= 1'b0;
      r_cpu_rdata <= 8'd0;
      r_rend_data <= 8'd0;
      r_rend_p1   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= w_complete;
      if (w_accept) begin
        r_we    <= i_cpu_we;
        r_wdata <= i_cpu_wdata;
      end
      // An explicit load wins over the completion increment.
      if (i_vaddr_load)    r_vaddr <= i_vaddr_in;
      else if (w_complete) r_vaddr <= r_vaddr + w_step;
      if (r_state == ST_RDWAIT) r_cpu_rdata <= i_vram_rdata;
      // Renderer data arrives one cycle after its strobe.
      r_rend_p1 <= w_rend_grant;
      if (r_rend_p1) r_rend_data <= i_vram_rdata;
    end
  end

  // Combinational outputs are held at zero while rst is asserted.
  assign o_vram_addr  = rst ? 14'd0 : w_vram_addr;
  assign o_vram_rd    = w_vram_rd & ~rst;
  assign o_vram_wr    = w_vram_wr & ~rst;
  assign o_vram_wdata = rst ? 8'd0 : w_vram_wdata;
  assign o_cpu_ack    = r_ack & ~rst;
  assign o_busy       = ~rst & ((r_state != ST_IDLE) | r_ack);
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_rend_data  = r_rend_data;
  assign o_state      = r_state;
  assign o_vaddr      = r_vaddr;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_rend = 1'b0;
  logic        i_fetch_nt = 1'b0, i_fetch_attr = 1'b0, i_fetch_chr = 1'b0;
  logic [13:0] i_rend_addr = 14'd0;
  logic [7:0]  o_rend_data;
  logic        i_vaddr_load = 1'b0;
  logic [13:0] i_vaddr_in = 14'd0;
  logic        i_inc32 = 1'b0;
  logic        i_cpu_req = 1'b0, i_cpu_we = 1'b0;
  logic [7:0]  i_cpu_wdata = 8'd0;
  logic        o_cpu_ack;
  logic [7:0]  o_cpu_rdata;
  logic        o_busy;
  logic [13:0] o_vram_addr;
  logic        o_vram_rd, o_vram_wr;
  logic [7:0]  o_vram_wdata;
  logic [7:0]  i_vram_rdata = 8'd0;
  logic [1:0]  o_state;
  logic [13:0] o_vaddr;

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rend(i_rend), .i_fetch_nt(i_fetch_nt), .i_fetch_attr(i_fetch_attr),
    .i_fetch_chr(i_fetch_chr), .i_rend_addr(i_rend_addr), .o_rend_data(o_rend_data),
    .i_vaddr_load(i_vaddr_load), .i_vaddr_in(i_vaddr_in), .i_inc32(i_inc32),
    .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata), .o_busy(o_busy),
    .o_vram_addr(o_vram_addr), .o_vram_rd(o_vram_rd), .o_vram_wr(o_vram_wr),
    .o_vram_wdata(o_vram_wdata), .i_vram_rdata(i_vram_rdata),
    .o_state(o_state), .o_vaddr(o_vaddr)
  );

  // ---------------- VRAM model ----------------
  logic [7:0] mem [16384];
  always @(posedge clk) begin
    if (o_vram_wr) mem[o_vram_addr] = o_vram_wdata;
    if (o_vram_rd) i_vram_rdata <= mem[o_vram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_ack    = 0;
  logic [13:0] exp_wr_addr_q[$];
  logic [7:0]  exp_wr_data_q[$];
  logic [13:0] exp_rd_addr_q[$];
  logic [7:0]  exp_ack_rdata_q[$];
  logic [13:0] exp_ack_vaddr_q[$];
  logic [7:0]  exp_rend_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  logic rs1 = 1'b0, rs2 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      rs1 = 1'b0;
      rs2 = 1'b0;
    end else begin
      if (rs2) begin
        if (exp_rend_q.size() == 0) chk("rend_unexpected", 1, 0);
        else chk("rend_data", {24'd0, o_rend_data}, {24'd0, exp_rend_q.pop_front()});
      end
      rs2 = rs1;
      rs1 = o_vram_rd & i_rend & (i_fetch_nt | i_fetch_attr | i_fetch_chr);
      if (o_vram_wr) begin
        if (exp_wr_addr_q.size() == 0) chk("wr_unexpected", {18'd0, o_vram_addr}, 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", {18'd0, o_vram_addr}, {18'd0, exp_wr_addr_q.pop_front()});
          chk("wr_data", {24'd0, o_vram_wdata}, {24'd0, exp_wr_data_q.pop_front()});
        end
      end
      if (o_vram_rd) begin
        if (exp_rd_addr_q.size() == 0) chk("rd_unexpected", {18'd0, o_vram_addr}, 32'hFFFF_FFFF);
        else chk("rd_addr", {18'd0, o_vram_addr}, {18'd0, exp_rd_addr_q.pop_front()});
      end
      if (o_cpu_ack) begin
        n_ack++;
        if (exp_ack_rdata_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          chk("ack_rdata", {24'd0, o_cpu_rdata}, {24'd0, exp_ack_rdata_q.pop_front()});
          chk("ack_vaddr", {18'd0, o_vaddr}, {18'd0, exp_ack_vaddr_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vaddr(input logic [13:0] a);
    i_vaddr_load = 1'b1;
    i_vaddr_in   = a;
    cyc();
    i_vaddr_load = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] d);
    i_cpu_req   = 1'b1;
    i_cpu_we    = we;
    i_cpu_wdata = d;
    cyc();
    i_cpu_req   = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && n_ack < target; i++) @(negedge clk);
    chk("ack_timeout", {31'd0, n_ack >= target}, 32'd1);
    cyc();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, {30'd0, o_state}, 0);
    chk({tag, "_vaddr"}, {18'd0, o_vaddr}, 0);
    chk({tag, "_cpu_rdata"}, {24'd0, o_cpu_rdata}, 0);
    chk({tag, "_rend_data"}, {24'd0, o_rend_data}, 0);
    chk({tag, "_ack"}, {31'd0, o_cpu_ack}, 0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 0);
    chk({tag, "_vram_rd"}, {31'd0, o_vram_rd}, 0);
    chk({tag, "_vram_wr"}, {31'd0, o_vram_wr}, 0);
    chk({tag, "_vram_addr"}, {18'd0, o_vram_addr}, 0);
    chk({tag, "_vram_wdata"}, {24'd0, o_vram_wdata}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int ack_before;
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2400] = 8'h11;
    mem[14'h2401] = 8'h22;
    mem[14'h2100] = 8'h33;
    for (int i = 0; i < 16; i++) mem[14'h0100 + i] = 8'hA0 + 8'(i);

    // reset state
    repeat (3) cyc();
    @(negedge clk);
    check_all_zero("reset");
    cyc();
    rst = 1'b0;
    cyc();

    // idle write at 0x2000
    load_vaddr(14'h2000);
    exp_wr_addr_q.push_back(14'h2000); exp_wr_data_q.push_back(8'h5A);
    exp_ack_rdata_q.push_back(8'h00);  exp_ack_vaddr_q.push_back(14'h2001);
    cpu_op(1'b1, 8'h5A);
    wait_acks(1, 20);

    // two buffered reads
    load_vaddr(14'h2400);
    exp_rd_addr_q.push_back(14'h2400);
    exp_ack_rdata_q.push_back(8'h11); exp_ack_vaddr_q.push_back(14'h2401);
    cpu_op(1'b0, 8'h00);
    wait_acks(2, 20);
    exp_rd_addr_q.push_back(14'h2401);
    exp_ack_rdata_q.push_back(8'h22); exp_ack_vaddr_q.push_back(14'h2402);
    cpu_op(1'b0, 8'h00);
    wait_acks(3, 20);

    // fetch strobe with renderer inactive: must not reach VRAM
    i_fetch_chr = 1'b1; i_rend_addr = 14'h0105;
    cyc();
    i_fetch_chr = 1'b0;

    // contention: renderer on even cycles, CPU read pulse on cycle 2
    load_vaddr(14'h2100);
    exp_rd_addr_q.push_back(14'h0100);
    exp_rd_addr_q.push_back(14'h0102);
    exp_rd_addr_q.push_back(14'h2100);
    exp_rd_addr_q.push_back(14'h0104);
    exp_rd_addr_q.push_back(14'h0106);
    exp_rend_q.push_back(8'hA0); exp_rend_q.push_back(8'hA2);
    exp_rend_q.push_back(8'hA4); exp_rend_q.push_back(8'hA6);
    exp_ack_rdata_q.push_back(8'h33); exp_ack_vaddr_q.push_back(14'h2101);
    i_rend = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_fetch_nt   = (k == 0) || (k == 6);
      i_fetch_attr = (k == 2);
      i_fetch_chr  = (k == 4);
      i_rend_addr  = 14'h0100 + 14'(k);
      i_cpu_req    = (k == 2);
      i_cpu_we     = 1'b0;
      cyc();
    end
    i_fetch_nt = 1'b0; i_fetch_attr = 1'b0; i_fetch_chr = 1'b0;
    i_cpu_req = 1'b0; i_rend = 1'b0;
    wait_acks(4, 20);

    // wrap: 0x3FF0 + 32 and 0x3FFF + 1
    load_vaddr(14'h3FF0);
    i_inc32 = 1'b1;
    exp_wr_addr_q.push_back(14'h3FF0); exp_wr_data_q.push_back(8'h77);
    exp_ack_rdata_q.push_back(8'h33);  exp_ack_vaddr_q.push_back(14'h0010);
    cpu_op(1'b1, 8'h77);
    wait_acks(5, 20);
    i_inc32 = 1'b0;
    load_vaddr(14'h3FFF);
    exp_wr_addr_q.push_back(14'h3FFF); exp_wr_data_q.push_back(8'h78);
    exp_ack_rdata_q.push_back(8'h33);  exp_ack_vaddr_q.push_back(14'h0000);
    cpu_op(1'b1, 8'h78);
    wait_acks(6, 20);

    // load during the completion/increment cycle wins
    load_vaddr(14'h0500);
    exp_wr_addr_q.push_back(14'h0500); exp_wr_data_q.push_back(8'h99);
    exp_ack_rdata_q.push_back(8'h33);  exp_ack_vaddr_q.push_back(14'h1234);
    cpu_op(1'b1, 8'h99);
    i_vaddr_load = 1'b1; i_vaddr_in = 14'h1234;
    cyc();
    i_vaddr_load = 1'b0;
    wait_acks(7, 20);

    // requests while busy are dropped; captured fields untouched
    load_vaddr(14'h0600);
    ack_before = n_ack;
    exp_rd_addr_q.push_back(14'h0108);
    exp_rend_q.push_back(8'hA8);
    exp_wr_addr_q.push_back(14'h0600); exp_wr_data_q.push_back(8'hAB);
    exp_ack_rdata_q.push_back(8'h33);  exp_ack_vaddr_q.push_back(14'h0601);
    cpu_op(1'b1, 8'hAB);
    i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_wdata = 8'hCD;
    i_rend = 1'b1; i_fetch_nt = 1'b1; i_rend_addr = 14'h0108;
    cyc();
    i_rend = 1'b0; i_fetch_nt = 1'b0;
    cyc();
    cyc();
    i_cpu_req = 1'b0;
    repeat (6) cyc();
    chk("busy_req_one_ack", n_ack - ack_before, 1);
    chk("busy_req_idle", {30'd0, o_state}, 0);

    // reset during RDWAIT abandons the read
    load_vaddr(14'h2400);
    exp_rd_addr_q.push_back(14'h2400);
    ack_before = n_ack;
    cpu_op(1'b0, 8'h00);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rdwait_state", {30'd0, o_state}, 2);
    cyc();
    @(negedge clk);
    check_all_zero("rst_rdwait");
    cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("rst_rdwait_no_ack", n_ack - ack_before, 0);
    chk("rst_rdwait_vaddr", {18'd0, o_vaddr}, 0);

    // every expected event consumed
    chk("q_wr_empty", exp_wr_addr_q.size(), 0);
    chk("q_rd_empty", exp_rd_addr_q.size(), 0);
    chk("q_ack_empty", exp_ack_rdata_q.size(), 0);
    chk("q_rend_empty", exp_rend_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rend  in  1  renderer active; fetch strobes honoured only when 1.
REQ-004 fetch_nt, fetch_attr, fetch_chr  in  1 each  renderer fetch strobes; at most one asserted per cycle.
REQ-005 rend_addr  in  14  VRAM address for the current renderer fetch.
REQ-006 rend_data  out  8  renderer read data, registered copy of vram_rdata.
REQ-007 vaddr_load  in  1  load CPU VRAM address register from vaddr_in.
REQ-008 vaddr_in  in  14  new CPU VRAM address.
REQ-009 inc32  in  1  CPU address increment select: 0 = +1, 1 = +32.
REQ-010 cpu_req  in  1  single-cycle pulse requesting one CPU VRAM access.
REQ-011 cpu_we  in  1  request type, sampled with cpu_req: 1 = write, 0 = read.
REQ-012 cpu_wdata  in  8  write data, sampled with cpu_req.
REQ-013 cpu_ack  out  1  one-cycle pulse when the CPU access completes.
REQ-014 cpu_rdata  out  8  read buffer: value returned to the CPU on the next read.
REQ-015 busy  out  1  CPU request pending or in flight.
REQ-016 vram_addr  out  14  VRAM address.
REQ-017 vram_rd, vram_wr  out  1 each  VRAM read and write strobes; mutually exclusive.
REQ-018 vram_wdata  out  8  VRAM write data.
REQ-019 vram_rdata  in  8  VRAM read data, valid the cycle after vram_rd.

Function
REQ-020 Bus ownership is decided combinationally each cycle: renderer fetch when rend and any fetch strobe is set, otherwise CPU when state is PEND, otherwise idle.
REQ-021 Renderer fetch: vram_addr=rend_addr, vram_rd=1 in the strobe cycle; rend_data=vram_rdata on the next edge (1-cycle latency).
REQ-022 Renderer fetches always win; a CPU access waits in PEND and issues on the first cycle with no honoured fetch strobe.
REQ-023 FSM states: IDLE, PEND, RDWAIT. IDLE->PEND on cpu_req, capturing cpu_we and cpu_wdata.
REQ-024 PEND with bus granted, write: vram_addr=vaddr, vram_wr=1, vram_wdata=captured data; next state IDLE; cpu_ack=1 the following cycle; vaddr increments.
REQ-025 PEND with bus granted, read: vram_addr=vaddr, vram_rd=1; next state RDWAIT.
REQ-026 RDWAIT: cpu_rdata<=vram_rdata; cpu_ack=1 the following cycle; vaddr increments; next state IDLE.
REQ-027 PEND without grant: no strobe; stay in PEND.
REQ-028 Increment is +1 or +32 per inc32, sampled at completion; result is 14-bit modulo (0x3FFF+1=0x0000, 0x3FF0+32=0x0010).
REQ-029 vaddr_load updates vaddr on the next edge and overrides a same-cycle increment; an issued access uses the address already driven.
REQ-030 cpu_req while busy=1 is ignored; captured request fields are not modified.
REQ-031 busy=1 in PEND and RDWAIT, and in the cpu_ack cycle.
REQ-032 Fetch strobes with rend=0 are ignored; no vram strobe is generated.
REQ-033 The cycle after a renderer read issue is free, so a CPU read issued there returns on the next cycle; the read pipeline needs no stall.

Reset
REQ-034 rst forces these values: state=IDLE, vaddr=0, cpu_rdata=0, rend_data=0, cpu_ack=0, busy=0, vram_rd=0, vram_wr=0, vram_addr=0, vram_wdata=0.
REQ-035 rst during PEND or RDWAIT abandons the access with no ack and no increment.

Verification
REQ-036 Idle write: vaddr_load 0x2000, cpu_req with we=1 and data 0x5A, rend=0 -> vram_wr next cycle at 0x2000 with 0x5A; cpu_ack one cycle later; vaddr=0x2001.
REQ-037 Buffered reads: VRAM[0x2400]=0x11 and VRAM[0x2401]=0x22, inc32=0, two reads -> after the first ack cpu_rdata=0x11; after the second, 0x22; vaddr=0x2402.
REQ-038 Contention: rend=1, strobes on even cycles, CPU read pulse on an even cycle -> CPU vram_rd on the next odd cycle; renderer rend_data is never corrupted.
REQ-039 Wrap: vaddr=0x3FF0, inc32=1, one write -> vaddr=0x0010. Then vaddr=0x3FFF, inc32=0, one write -> vaddr=0x0000.
REQ-040 Collisions: vaddr_load in the ack-increment cycle -> vaddr=vaddr_in. cpu_req while busy -> exactly one ack. rst in RDWAIT -> no ack, all outputs zero.
